clk_div_multi: RTL and testbench

- Multi-channel programmable clock/tick generator. Successor to the single fixed-divisor toggle divider.
- Each of NUM_CH channels has a runtime-loadable divisor, a per-channel enable, a 50%-duty divided clock output and a one-cycle tick strobe.
- Sits beside the top-level game logic. It supplies the display-refresh, debounce, game-step and sound-rate timebases from one system clock.

---
 rtl/clk_div_multi.sv | 61 ++++++
 tb/tb_clk_div_multi.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock/tick generator: each channel divides clk by a
// runtime-loadable divisor and produces a 50%-duty clock plus a one-cycle tick.
module clk_div_multi #(
    parameter int NUM_CH      = 4,
    parameter int CNT_W       = 32,
    parameter int DEFAULT_DIV = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] en,
    input  logic              sync,
    input  logic              load,
    input  logic [3:0]        load_ch,
    input  logic [CNT_W-1:0]  load_val,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] tick
);

    logic [CNT_W-1:0] div_q   [NUM_CH];
    logic [CNT_W-1:0] count_q [NUM_CH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                div_q[i]   <= CNT_W'(DEFAULT_DIV);
                count_q[i] <= '0;
            end
            clk_out <= '0;
            tick    <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                // An out-of-range load_ch never matches any channel, so it is ignored.
                if (load && (load_ch == 4'(i))) begin
                    div_q[i] <= load_val;
                end

                // sync dominates a same-cycle load's phase reset; the divisor write above still lands.
                if (sync) begin
                    count_q[i] <= '0;
                    clk_out[i] <= 1'b0;
                    tick[i]    <= 1'b0;
                end else if (load && (load_ch == 4'(i))) begin
                    count_q[i] <= '0;
                    tick[i]    <= 1'b0;
                end else if (en[i]) begin
                    if (count_q[i] == div_q[i]) begin
                        count_q[i] <= '0;
                        clk_out[i] <= ~clk_out[i];
                        tick[i]    <= 1'b1;
                    end else begin
                        count_q[i] <= count_q[i] + 1'b1;
                        tick[i]    <= 1'b0;
                    end
                end else begin
                    tick[i] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_clk_div_multi.sv
// Self-checking bench for clk_div_multi: a period-arithmetic model checked every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_clk_div_multi;

    localparam int NUM_CH = 4;
    localparam int CNT_W  = 32;
    localparam int DEF    = 1;

    logic              clk = 1'b0;
    logic              rst;
    logic [NUM_CH-1:0] en;
    logic              sync;
    logic              load;
    logic [3:0]        load_ch;
    logic [CNT_W-1:0]  load_val;
    logic [NUM_CH-1:0] clk_out;
    logic [NUM_CH-1:0] tick;

    int checks = 0;
    int errors = 0;

    clk_div_multi #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .DEFAULT_DIV(DEF)) dut (
        .clk(clk), .rst(rst), .en(en), .sync(sync), .load(load),
        .load_ch(load_ch), .load_val(load_val), .clk_out(clk_out), .tick(tick)
    );

    always #5 clk = ~clk;

    // Model: n = enabled cycles since the last phase restart; clk_out flips once per
    // completed period (div+1), starting from the level held at the restart.
    longint            n    [NUM_CH];
    longint            mdiv [NUM_CH];
    logic              base [NUM_CH];
    logic [NUM_CH-1:0] m_tick;
    logic [NUM_CH-1:0] m_clk;
    logic              model_valid = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                mdiv[i] = DEF; n[i] = 0; base[i] = 1'b0;
            end
            m_tick = '0; m_clk = '0; model_valid = 1'b1;
        end else if (model_valid) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (load && load_ch == i) mdiv[i] = longint'(load_val);
                if (sync) begin
                    n[i] = 0; base[i] = 1'b0; m_tick[i] = 1'b0;
                end else if (load && load_ch == i) begin
                    base[i] = m_clk[i]; n[i] = 0; m_tick[i] = 1'b0;
                end else if (en[i]) begin
                    n[i] = n[i] + 1;
                    m_tick[i] = (n[i] % (mdiv[i] + 1)) == 0;
                end else begin
                    m_tick[i] = 1'b0;
                end
                m_clk[i] = base[i] ^ (((n[i] / (mdiv[i] + 1)) % 2) == 1);
            end
        end
    end

    task automatic check(input string name, input logic [NUM_CH-1:0] act,
                         input logic [NUM_CH-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (model_valid) begin
            check("model_tick", tick, m_tick);
            check("model_clk_out", clk_out, m_clk);
        end
    end

    task automatic do_load(input logic [3:0] ch, input logic [CNT_W-1:0] val);
        @(negedge clk);
        load = 1'b1; load_ch = ch; load_val = val;
        @(negedge clk);
        load = 1'b0;
    endtask

    logic              held;
    logic              prev;
    logic              found;
    logic [NUM_CH-1:0] en_tab [6] = '{4'b1111, 4'b0101, 4'b1010, 4'b0000, 4'b1100, 4'b1111};

    initial begin
        rst = 1'b1; en = '0; sync = 1'b0; load = 1'b0; load_ch = '0; load_val = '0;
        repeat (2) @(negedge clk);
        check("reset_tick", tick, 4'b0000);
        check("reset_clk_out", clk_out, 4'b0000);

        // Reset release, DEFAULT_DIV=1: first tick after edge 2, clk_out period 4.
        rst = 1'b0; en = '1;
        @(negedge clk); check("edge1_tick", tick, 4'b0000); check("edge1_clk", clk_out, 4'b0000);
        @(negedge clk); check("edge2_tick", tick, 4'b1111); check("edge2_clk", clk_out, 4'b1111);
        @(negedge clk); check("edge3_tick", tick, 4'b0000); check("edge3_clk", clk_out, 4'b1111);
        @(negedge clk); check("edge4_tick", tick, 4'b1111); check("edge4_clk", clk_out, 4'b0000);

        // Load ch1 with 4 mid-count: tick[1] exactly 5 cycles after the load edge.
        @(negedge clk);
        load = 1'b1; load_ch = 4'd1; load_val = 32'd4;
        @(negedge clk);
        load = 1'b0;
        for (int j = 1; j <= 5; j++) begin
            @(negedge clk);
            check($sformatf("load_tick1_c%0d", j), {3'b000, tick[1]}, {3'b000, j == 5});
        end
        repeat (20) @(negedge clk);

        // Enable gating on ch2 starting right after a tick (count[2]=0).
        found = 1'b0;
        for (int k = 0; k < 4 && !found; k++) begin
            @(negedge clk);
            if (tick[2]) found = 1'b1;
        end
        check("gate_found_tick2", {3'b000, found}, 4'b0001);
        held = clk_out[2];
        en = 4'b1011;
        for (int j = 1; j <= 3; j++) begin
            @(negedge clk);
            check("gap_tick2", {3'b000, tick[2]}, 4'b0000);
            check("gap_clk2", {3'b000, clk_out[2]}, {3'b000, held});
        end
        en = 4'b1111;
        @(negedge clk); check("reen1_tick2", {3'b000, tick[2]}, 4'b0000);
        @(negedge clk); check("reen2_tick2", {3'b000, tick[2]}, 4'b0001);

        // div=0 on ch0: tick constant 1, clk_out toggles each cycle.
        do_load(4'd0, 32'd0);
        check("div0_load_tick0", {3'b000, tick[0]}, 4'b0000);
        prev = clk_out[0];
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            check("div0_tick0", {3'b000, tick[0]}, 4'b0001);
            check("div0_toggle0", {3'b000, clk_out[0]}, {3'b000, ~prev});
            prev = clk_out[0];
        end
        // Out-of-range load is ignored; ch0 keeps ticking every cycle.
        do_load(4'd7, 32'd9);
        repeat (3) @(negedge clk);
        check("oor_tick0", {3'b000, tick[0]}, 4'b0001);

        // Sync alignment with divisors 1,2,3,4.
        do_load(4'd0, 32'd1);
        do_load(4'd1, 32'd2);
        do_load(4'd2, 32'd3);
        do_load(4'd3, 32'd4);
        repeat (17) @(negedge clk);
        sync = 1'b1;
        @(negedge clk);
        sync = 1'b0;
        check("sync_clk_out", clk_out, 4'b0000);
        check("sync_tick", tick, 4'b0000);
        for (int j = 1; j <= 60; j++) begin
            @(negedge clk);
            if (j == 4)  check("sync_c4_tick", tick, 4'b0101);
            if (j == 12) check("sync_c12_tick", tick, 4'b0111);
            if (j == 60) check("sync_c60_tick", tick, 4'b1111);
        end

        // Enable pattern sweep under the model.
        foreach (en_tab[e]) begin
            en = en_tab[e];
            repeat (5) @(negedge clk);
        end

        // sync + load together: ch3 divisor 2 written, all phases restart.
        @(negedge clk);
        sync = 1'b1; load = 1'b1; load_ch = 4'd3; load_val = 32'd2;
        @(negedge clk);
        sync = 1'b0; load = 1'b0;
        check("syncload_clk_out", clk_out, 4'b0000);
        check("syncload_tick", tick, 4'b0000);
        @(negedge clk);
        @(negedge clk); check("syncload_c2_tick", tick, 4'b0001);
        @(negedge clk); check("syncload_c3_tick", tick, 4'b1010);

        // rst with load and sync in the same cycle: reset wins.
        repeat (3) @(negedge clk);
        rst = 1'b1; sync = 1'b1; load = 1'b1; load_ch = 4'd1; load_val = 32'd7;
        @(negedge clk);
        check("rstcol_clk_out", clk_out, 4'b0000);
        check("rstcol_tick", tick, 4'b0000);
        rst = 1'b0; sync = 1'b0; load = 1'b0; en = '1;
        @(negedge clk); check("rstcol_e1_tick", tick, 4'b0000);
        @(negedge clk); check("rstcol_e2_tick", tick, 4'b1111);
        repeat (6) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
